// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: assembles 32-bit memory words into 64-bit bundles
// fetched sequentially ahead of the core, flushing and refetching on any address miss.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [28:0] IN_instrAddr,
  input  logic        IN_instrReadEnable,
  output logic [63:0] OUT_instrRaw,
  output logic        OUT_ready,
  output logic        OUT_MEM_req,
  output logic [29:0] OUT_MEM_addr,
  input  logic        IN_MEM_ack,
  input  logic        IN_MEM_rvalid,
  input  logic [31:0] IN_MEM_rdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(MAX_OUT + 1);
  localparam int unsigned DW = 8;
  localparam int unsigned OW = $clog2(2 * DEPTH + MAX_OUT + 2);

  logic [63:0]   queue_q [DEPTH];
  logic [28:0]   head_addr_q, head_addr_d;
  logic [29:0]   issue_addr_q, issue_addr_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [PW-1:0] tail_ptr_q, tail_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   word0_q, word0_d;
  logic          half_q, half_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [DW-1:0] discard_q, discard_d;
  logic [63:0]   raw_q, raw_d;
  logic          started_q;

  logic          redirect_c;
  logic          pop_c;
  logic          push_c;
  logic          req_c;
  logic          fill_c;
  logic [OW-1:0] occupancy_c;

  // Words already committed to the queue: buffered bundles, the half bundle, and in flight.
  assign occupancy_c = OW'({count_q, 1'b0}) + OW'(half_q) + OW'(inflight_q);
  assign redirect_c  = (IN_instrAddr != head_addr_q);
  assign pop_c       = (count_q != '0) && !redirect_c && !IN_instrReadEnable;
  assign req_c       = started_q && !redirect_c && (inflight_q < IW'(MAX_OUT))
                       && (occupancy_c < OW'(2 * DEPTH));
  assign fill_c      = IN_MEM_rvalid && (discard_q == '0);

  assign OUT_ready    = (count_q != '0) && !redirect_c;
  assign OUT_MEM_req  = req_c;
  assign OUT_MEM_addr = issue_addr_q;
  assign OUT_instrRaw = raw_q;

  always_comb begin
    head_addr_d  = head_addr_q;
    issue_addr_d = issue_addr_q;
    head_ptr_d   = head_ptr_q;
    tail_ptr_d   = tail_ptr_q;
    count_d      = count_q;
    word0_d      = word0_q;
    half_d       = half_q;
    inflight_d   = inflight_q;
    discard_d    = discard_q;
    raw_d        = raw_q;
    push_c       = 1'b0;

    if (redirect_c) begin
      // Everything outstanding becomes stale, including a response landing right now.
      head_addr_d  = IN_instrAddr;
      issue_addr_d = {IN_instrAddr, 1'b0};
      head_ptr_d   = '0;
      tail_ptr_d   = '0;
      count_d      = '0;
      half_d       = 1'b0;
      inflight_d   = '0;
      discard_d    = discard_q + DW'(inflight_q) + DW'(IN_MEM_ack) - DW'(IN_MEM_rvalid);
    end else begin
      if (IN_MEM_ack) begin
        issue_addr_d = issue_addr_q + 30'd1;
      end
      inflight_d = inflight_q + IW'(IN_MEM_ack) - IW'(fill_c);

      if (IN_MEM_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - DW'(1);
      end else if (fill_c && !half_q) begin
        word0_d = IN_MEM_rdata;
        half_d  = 1'b1;
      end else if (fill_c) begin
        push_c  = 1'b1;
        half_d  = 1'b0;
      end

      if (pop_c) begin
        raw_d       = queue_q[head_ptr_q];
        head_ptr_d  = head_ptr_q + PW'(1);
        head_addr_d = head_addr_q + 29'd1;
      end
      if (push_c) begin
        tail_ptr_d = tail_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_addr_q  <= '0;
      issue_addr_q <= '0;
      head_ptr_q   <= '0;
      tail_ptr_q   <= '0;
      count_q      <= '0;
      word0_q      <= '0;
      half_q       <= 1'b0;
      inflight_q   <= '0;
      discard_q    <= '0;
      raw_q        <= '0;
      started_q    <= 1'b0;
    end else begin
      head_addr_q  <= head_addr_d;
      issue_addr_q <= issue_addr_d;
      head_ptr_q   <= head_ptr_d;
      tail_ptr_q   <= tail_ptr_d;
      count_q      <= count_d;
      word0_q      <= word0_d;
      half_q       <= half_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      raw_q        <= raw_d;
      started_q    <= 1'b1;
    end
  end

  // Bundle storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      queue_q[tail_ptr_q] <= {IN_MEM_rdata, word0_q};
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer with an in-order, fixed-latency memory model.
module tb_fetch_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [28:0] instr_addr;
  logic        ren;
  logic [63:0] raw;
  logic        ready;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = '0;

  logic        ack_en = 1'b1;
  int unsigned lat = 1;
  int unsigned cyc = 0;
  int unsigned ack_cnt = 0;
  int unsigned pop_cnt = 0;
  logic        track_occ = 1'b1;
  int          max_occ = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int unsigned due;
    logic [29:0] addr;
  } pend_t;
  pend_t pend[$];

  always #5 clk = ~clk;

  fetch_prefetch_buffer #(.DEPTH(4), .MAX_OUT(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .IN_instrAddr      (instr_addr),
    .IN_instrReadEnable(ren),
    .OUT_instrRaw      (raw),
    .OUT_ready         (ready),
    .OUT_MEM_req       (mem_req),
    .OUT_MEM_addr      (mem_addr),
    .IN_MEM_ack        (mem_ack),
    .IN_MEM_rvalid     (mem_rvalid),
    .IN_MEM_rdata      (mem_rdata)
  );

  assign mem_ack = mem_req && ack_en;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b00, a} * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [63:0] bundle(input logic [28:0] b);
    return {mem_word({b, 1'b1}), mem_word({b, 1'b0})};
  endfunction

  // Accepted requests are recorded mid-cycle; responses appear at the start of cycle ack+lat.
  always @(negedge clk) begin
    int occ;
    if (mem_ack) begin
      pend.push_back('{cyc + lat, mem_addr});
      ack_cnt = ack_cnt + 1;
    end
    if (track_occ) begin
      occ = int'(ack_cnt) - 2 * int'(pop_cnt);
      if (occ > max_occ) max_occ = occ;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    mem_rvalid = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int c = 0;
    while (!ready && c < 50) begin
      tick;
      settle;
      c++;
    end
    check_eq(tag, 64'(ready), 64'd1);
  endtask

  int          b;
  logic        have_exp;
  logic [63:0] exp_raw;
  int unsigned a0;

  initial begin
    rst = 1'b0;
    instr_addr = '0;
    ren = 1'b1;
    repeat (3) tick;
    settle;
    check_eq("rst_raw", raw, 64'd0);
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_req", 64'(mem_req), 64'd0);
    check_eq("rst_addr", 64'(mem_addr), 64'd0);

    // Cycle 0 is the first cycle with reset released.
    tick; rst = 1'b1; settle;
    check_eq("req_c0", 64'(mem_req), 64'd0);
    tick; settle;
    check_eq("req_c1", 64'(mem_req), 64'd1);
    check_eq("addr_c1", 64'(mem_addr), 64'd0);
    tick; settle;
    check_eq("addr_c2", 64'(mem_addr), 64'd1);
    check_eq("ready_c2", 64'(ready), 64'd0);
    tick; settle;
    check_eq("addr_c3", 64'(mem_addr), 64'd2);
    check_eq("ready_c3", 64'(ready), 64'd0);
    tick; ren = 1'b0; settle;
    check_eq("ready_c4", 64'(ready), 64'd1);
    pop_cnt++;
    tick; instr_addr = 29'd1; ren = 1'b1; settle;
    check_eq("raw_b0", raw, bundle(29'd0));

    // Streaming: consume whenever ready, address following the head.
    b = 1;
    have_exp = 1'b0;
    for (int c = 0; c < 300 && b < 16; c++) begin
      tick; instr_addr = 29'(b); ren = 1'b0; settle;
      if (have_exp) begin
        check_eq("stream_data", raw, exp_raw);
        have_exp = 1'b0;
      end
      if (ready) begin
        exp_raw = bundle(29'(b));
        have_exp = 1'b1;
        b++;
        pop_cnt++;
      end
    end
    tick; instr_addr = 29'(b); ren = 1'b1; settle;
    if (have_exp) check_eq("stream_data", raw, exp_raw);
    check_eq("stream_done", 64'(b), 64'd16);

    // Core idle: queue fills, requests stop; one pop frees exactly two words.
    repeat (20) tick;
    settle;
    check_eq("full_req", 64'(mem_req), 64'd0);
    check_eq("full_ready", 64'(ready), 64'd1);
    check_eq("full_words", 64'(ack_cnt - 2 * pop_cnt), 64'd8);
    ren = 1'b0; settle;
    pop_cnt++;
    a0 = ack_cnt;
    tick; instr_addr = 29'd17; ren = 1'b1; settle;
    check_eq("idle_pop_data", raw, bundle(29'd16));
    repeat (10) tick;
    settle;
    check_eq("refill_reqs", 64'(ack_cnt - a0), 64'd2);
    check_eq("refill_req_low", 64'(mem_req), 64'd0);
    track_occ = 1'b0;
    check_eq("max_occ_le8", 64'(max_occ <= 8), 64'd1);

    // Redirect to 0x10 with latency 3, then to 0x100 while three words are in flight.
    lat = 3;
    tick; instr_addr = 29'h10; settle;
    check_eq("redir10_ready", 64'(ready), 64'd0);
    repeat (4) tick;
    instr_addr = 29'h100; settle;
    check_eq("redir100_ready", 64'(ready), 64'd0);
    tick; settle;
    check_eq("redir100_req", 64'(mem_req), 64'd1);
    check_eq("redir100_addr", 64'(mem_addr), 64'h200);
    for (int k = 2; k <= 5; k++) begin
      tick; settle;
      check_eq("stale_ready_low", 64'(ready), 64'd0);
    end
    tick; ren = 1'b0; settle;
    check_eq("redir100_ready_r6", 64'(ready), 64'd1);
    tick; instr_addr = 29'h101; ren = 1'b1; settle;
    check_eq("redir100_data", raw, bundle(29'h100));

    // Redirect while the old head is valid and the core asserts a read: redirect wins.
    wait_ready("ready_101");
    tick; instr_addr = 29'h300; ren = 1'b0; settle;
    check_eq("redir_pop_ready", 64'(ready), 64'd0);
    tick; ren = 1'b1; settle;
    check_eq("redir_raw_hold", raw, bundle(29'h100));
    check_eq("redir_head_req", 64'(mem_req), 64'd1);
    check_eq("redir_head_addr", 64'(mem_addr), 64'h600);

    // Address wrap at the top of the space.
    lat = 1;
    repeat (6) tick;
    instr_addr = 29'h1FFF_FFFF; settle;
    tick; settle;
    check_eq("wrap_addr0", 64'(mem_addr), 64'h3FFF_FFFE);
    tick; settle;
    check_eq("wrap_addr1", 64'(mem_addr), 64'h3FFF_FFFF);
    tick; settle;
    check_eq("wrap_addr2", 64'(mem_addr), 64'h0);
    tick; settle;
    check_eq("wrap_addr3", 64'(mem_addr), 64'h1);
    check_eq("wrap_req3", 64'(mem_req), 64'd1);
    wait_ready("wrap_ready_top");
    ren = 1'b0; settle;
    tick; instr_addr = 29'd0; ren = 1'b1; settle;
    check_eq("wrap_data_top", raw, bundle(29'h1FFF_FFFF));
    wait_ready("wrap_ready_zero");
    ren = 1'b0; settle;
    tick; instr_addr = 29'd1; ren = 1'b1; settle;
    check_eq("wrap_data_zero", raw, bundle(29'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
